// File: rtl/lpm_arb_pkg.sv
// Shared types and constants for the LPM enqueue arbiter slice.
`timescale 1ns/1ps
package lpm_arb_pkg;
   localparam int NREQ_DEF   = 4;
   localparam int DATA_W_DEF = 128;
   localparam int STAT_W     = 16;
   localparam int TAG_W_DEF  = $clog2(NREQ_DEF);

   typedef logic [TAG_W_DEF-1:0]  tag_t;
   typedef logic [DATA_W_DEF-1:0] payload_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } arb_state_t;
endpackage

// File: rtl/lpm_enq_arbiter_if.sv
// Requester, holding-FIFO and consumer signals of the LPM enqueue arbiter.
// Every ENA/RDY pair executes in a cycle only when both are high; RDY never looks at its own ENA.
`timescale 1ns/1ps
interface lpm_enq_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 128,
   localparam int TAG_W = $clog2(NREQ)
);
   logic [NREQ-1:0]        req_enq_ena;
   logic [NREQ*DATA_W-1:0] req_enq_v;
   logic [NREQ-1:0]        req_enq_rdy;
   logic                   fifo_enq_ena;
   logic [DATA_W-1:0]      fifo_enq_v;
   logic                   fifo_deq_ena;
   logic [DATA_W-1:0]      fifo_first;
   logic                   out_deq_ena;
   logic                   out_deq_rdy;
   logic [DATA_W-1:0]      out_first;
   logic                   out_first_rdy;
   logic [TAG_W-1:0]       out_tag;

   modport master (
      output req_enq_ena, req_enq_v, fifo_first, out_deq_ena,
      input  req_enq_rdy, fifo_enq_ena, fifo_enq_v, fifo_deq_ena,
             out_deq_rdy, out_first, out_first_rdy, out_tag
   );

   modport slave (
      input  req_enq_ena, req_enq_v, fifo_first, out_deq_ena,
      output req_enq_rdy, fifo_enq_ena, fifo_enq_v, fifo_deq_ena,
             out_deq_rdy, out_first, out_first_rdy, out_tag
   );
endinterface

// File: rtl/lpm_rr_pick.sv
// Combinational round-robin picker: scan starts at ptr and wraps modulo NREQ.
`timescale 1ns/1ps
module lpm_rr_pick #(
   parameter int NREQ   = 4,
   localparam int TAG_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [TAG_W-1:0] ptr,
   input  logic             en,
   output logic [NREQ-1:0]  rdy,
   output logic [TAG_W-1:0] win,
   output logic             any
);
   logic seen;
   int   idx;

   // rdy[i] only depends on requesters ahead of i in scan order, never on req[i].
   always_comb begin
      rdy  = '0;
      win  = '0;
      any  = 1'b0;
      seen = 1'b0;
      idx  = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx      = (int'(ptr) + k) % NREQ;
         rdy[idx] = en & ~seen;
         if (req[idx] && !seen) begin
            win = TAG_W'(idx);
            any = en;
         end
         seen = seen | req[idx];
      end
   end
endmodule

// File: rtl/lpm_enq_arbiter.sv
// Round-robin share of one single-entry holding FIFO, with occupancy tracking and requester tags.
// Optional per-requester grant counters are built when LPM_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module lpm_enq_arbiter
   import lpm_arb_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int DATA_W = DATA_W_DEF,
   localparam int TAG_W = $clog2(NREQ)
) (
   input  logic                 CLK,
   input  logic                 nRST,
   lpm_enq_arbiter_if.slave     bus,
`ifdef LPM_ARB_STATS_EN
   input  logic                 stat_clear,
   output logic [NREQ*STAT_W-1:0] stat_grants,
`endif
   output arb_state_t           dbg_state,
   output logic [TAG_W-1:0]     dbg_rr_ptr
);
   arb_state_t       state_q, state_d;
   logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [NREQ-1:0]  rdy;
   logic [NREQ-1:0]  exec;
   logic [TAG_W-1:0] win;
   logic             any;
   logic             full;
   logic             enq;
   logic             deq;

   assign full = (state_q == ST_FULL);

   lpm_rr_pick #(.NREQ(NREQ)) u_pick (
      .req (bus.req_enq_ena),
      .ptr (rr_ptr_q),
      .en  (~full),
      .rdy (rdy),
      .win (win),
      .any (any)
   );

   assign exec = bus.req_enq_ena & rdy;
   assign enq  = any;
   assign deq  = bus.out_deq_ena & full;

   assign bus.req_enq_rdy   = rdy;
   assign bus.fifo_enq_ena  = enq;
   assign bus.fifo_enq_v    = bus.req_enq_v[int'(win)*DATA_W +: DATA_W];
   assign bus.fifo_deq_ena  = deq;
   assign bus.out_deq_rdy   = full;
   assign bus.out_first_rdy = full;
   assign bus.out_first     = bus.fifo_first;
   assign bus.out_tag       = tag_q;

   assign dbg_state  = state_q;
   assign dbg_rr_ptr = rr_ptr_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= ST_EMPTY;
         rr_ptr_q <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         tag_q    <= tag_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      tag_d    = tag_q;
      case (state_q)
         ST_EMPTY: begin
            if (enq) begin
               state_d  = ST_FULL;
               tag_d    = win;
               rr_ptr_d = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
            end
         end
         ST_FULL: begin
            if (deq) state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

`ifdef LPM_ARB_STATS_EN
   logic [STAT_W-1:0] cnt_q [NREQ];

   // Clear wins over increment; counters stick at all-ones.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < NREQ; i++) begin
         if (!nRST || stat_clear) cnt_q[i] <= '0;
         else if (exec[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_stat
      assign stat_grants[g*STAT_W +: STAT_W] = cnt_q[g];
   end
`else
   logic unused_exec;
   assign unused_exec = ^exec;
`endif
endmodule
